// File: rtl/ptw_mem_arbiter_pkg.sv
// Shared types for the page-table-walker memory path: cache request/response
// bundles, fault types and the two-port arbiter port identifier.
package ptw_mem_arbiter_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        FE_ACCESS_FAULT = 2'd0,
        FE_PAGE_FAULT   = 2'd1,
        FE_MISALIGNED   = 2'd2
    } FaultTy;

    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } ArbPort;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        logic              wen;
        logic [DATA_W-1:0] wdata;
    } CacheReq;

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] rdata;
        logic              error;
        FaultTy            errty;
    } CacheResp;

    // Value every response port shows when it is not carrying a live response.
    localparam CacheResp RESP_IDLE = '{valid: 1'b0, rdata: '0, error: 1'b0, errty: FE_ACCESS_FAULT};

    function automatic ArbPort otherPort(input ArbPort p);
        return (p == PORT_I) ? PORT_D : PORT_I;
    endfunction

endpackage

// File: rtl/rr_grant2.sv
// Two-requester grant picker: a sole requester always wins; on a tie either
// port I wins (fixed priority) or the port not granted last wins.
module rr_grant2
    import ptw_mem_arbiter_pkg::*;
#(
    parameter bit FIXED_PRIORITY = 1'b0
) (
    input  logic       validI_i,
    input  logic       validD_i,
    input  ArbPort     lastGrant_i,
    output logic [1:0] grant_o
);

    // grant_o[0] selects port I, grant_o[1] selects port D.
    always_comb begin
        grant_o = 2'b00;
        if (validI_i && validD_i) begin
            if (FIXED_PRIORITY || (otherPort(lastGrant_i) == PORT_I)) begin
                grant_o = 2'b01;
            end else begin
                grant_o = 2'b10;
            end
        end else if (validI_i) begin
            grant_o = 2'b01;
        end else if (validD_i) begin
            grant_o = 2'b10;
        end
    end

endmodule

// File: rtl/ptw_mem_arbiter.sv
// Arbitrates the instruction- and data-side page table walkers onto one memory
// port with a single transaction in flight.
module ptw_mem_arbiter
    import ptw_mem_arbiter_pkg::*;
#(
    parameter int FIXED_PRIORITY = 0,
    parameter int LOG_ENABLE     = 0
) (
    input  logic     clk,
    input  logic     reset_n,
    input  CacheReq  ireq_i,
    output logic     ireq_ready_o,
    output CacheResp iresp_o,
    input  CacheReq  dreq_i,
    output logic     dreq_ready_o,
    output CacheResp dresp_o,
    output CacheReq  memreq_o,
    input  logic     memreq_ready_i,
    input  CacheResp memresp_i
`ifdef PRINT_DEBUGINFO
    ,
    input  logic     can_output_log
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_RESP
    } state_e;

    state_e            state_q, state_d;
    ArbPort            lastGrant_q, lastGrant_d;
    ArbPort            owner_q, owner_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wen_q, wen_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [1:0]        grant;

    rr_grant2 #(
        .FIXED_PRIORITY (FIXED_PRIORITY != 0)
    ) u_grant (
        .validI_i    (ireq_i.valid),
        .validD_i    (dreq_i.valid),
        .lastGrant_i (lastGrant_q),
        .grant_o     (grant)
    );

    // Writes also wait for their response so the memory never sees two in flight.
    always_comb begin
        state_d      = state_q;
        lastGrant_d  = lastGrant_q;
        owner_d      = owner_q;
        addr_d       = addr_q;
        wen_d        = wen_q;
        wdata_d      = wdata_q;
        ireq_ready_o = 1'b0;
        dreq_ready_o = 1'b0;
        memreq_o     = '{valid: 1'b0, addr: addr_q, wen: wen_q, wdata: wdata_q};
        iresp_o      = RESP_IDLE;
        dresp_o      = RESP_IDLE;

        case (state_q)
            IDLE: begin
                ireq_ready_o = grant[0];
                dreq_ready_o = grant[1];
                if (grant[0]) begin
                    owner_d     = PORT_I;
                    lastGrant_d = PORT_I;
                    addr_d      = ireq_i.addr;
                    wen_d       = ireq_i.wen;
                    wdata_d     = ireq_i.wdata;
                    state_d     = ISSUE;
                end else if (grant[1]) begin
                    owner_d     = PORT_D;
                    lastGrant_d = PORT_D;
                    addr_d      = dreq_i.addr;
                    wen_d       = dreq_i.wen;
                    wdata_d     = dreq_i.wdata;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                memreq_o.valid = 1'b1;
                if (memreq_ready_i) begin
                    state_d = WAIT_RESP;
                end
            end
            WAIT_RESP: begin
                if (owner_q == PORT_I) begin
                    iresp_o = memresp_i;
                end else begin
                    dresp_o = memresp_i;
                end
                if (memresp_i.valid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (!reset_n) begin
            ireq_ready_o   = 1'b0;
            dreq_ready_o   = 1'b0;
            memreq_o.valid = 1'b0;
            iresp_o.valid  = 1'b0;
            dresp_o.valid  = 1'b0;
        end
    end

    // Port I must win the first tie after reset, hence lastGrant starts at D.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            lastGrant_q <= PORT_D;
            owner_q     <= PORT_I;
            addr_q      <= '0;
            wen_q       <= 1'b0;
            wdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            lastGrant_q <= lastGrant_d;
            owner_q     <= owner_d;
            addr_q      <= addr_d;
            wen_q       <= wen_d;
            wdata_q     <= wdata_d;
        end
    end

    generate
        if (LOG_ENABLE != 0) begin : g_log
`ifdef PRINT_DEBUGINFO
            logic logFire;
            assign logFire = can_output_log & (state_q == IDLE) & (|grant);
`endif
        end
    endgenerate

endmodule

// File: doc/ptw_mem_arbiter.md
PTW_MEM_ARBITER -- requirements
Module: ptw_mem_arbiter

Interface
REQ-001 SHALL have parameter FIXED_PRIORITY, default 0; 0 = round-robin grant, 1 = port I always wins ties.
REQ-002 SHALL have parameter LOG_ENABLE, default 0; 1 = emit debug display under PRINT_DEBUGINFO, no functional effect.
REQ-003 SHALL have port clk, input, 1 bit; the single clock, all state updates on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit; asynchronous, active-low reset.
REQ-005 SHALL have ports ireq/iresp, inout, CacheReq/CacheResp; port I, fed by the instruction-side PageTableWalker memreq/memresp.
REQ-006 SHALL have ports dreq/dresp, inout, CacheReq/CacheResp; port D, fed by the data-side PageTableWalker memreq/memresp.
REQ-007 SHALL have ports memreq/memresp, inout, CacheReq/CacheResp; the single downstream memory port.
REQ-008 SHALL have port can_output_log, input, 1 bit, present only under PRINT_DEBUGINFO; gates logging.

Function
REQ-009 SHALL implement states IDLE, ISSUE and WAIT_RESP, with exactly one transaction outstanding at any time.
REQ-010 SHALL drive ireq.ready and dreq.ready combinationally, high only in IDLE and only for the granted port; a port is granted only while its valid is high.
REQ-011 SHALL grant a sole requester in IDLE.
REQ-012 SHALL resolve simultaneous requests as follows: FIXED_PRIORITY=1 -> port I wins; FIXED_PRIORITY=0 -> the port not granted last wins.
REQ-013 SHALL update last_grant only on an accepted handshake (valid & ready).
REQ-014 SHALL, on acceptance, latch addr, wen, wdata and the owner id, then move IDLE -> ISSUE on the next edge; requester fields may change freely after acceptance.
REQ-015 SHALL hold memreq.valid high in ISSUE only, with the latched addr/wen/wdata; on memreq.ready it moves ISSUE -> WAIT_RESP.
REQ-016 SHALL, in WAIT_RESP, forward memresp.valid/rdata/error/errty combinationally to the owner's resp in the same cycle, then move to IDLE on the next edge.
REQ-017 SHALL hold the non-owner's resp.valid at 0 at all times.
REQ-018 SHALL treat writes (wen=1) the same as reads: a response is awaited even when the requester does not wait for it (the PTW A/D-bit write); no new grant occurs until that response arrives.
REQ-019 SHALL ignore memresp.valid outside WAIT_RESP; such a response is dropped and not forwarded.
REQ-020 SHALL pass memresp.error/errty through unchanged; the arbiter generates no faults itself.
REQ-021 SHALL give a minimum latency of: accept at cycle N, memreq.valid at N+1, owner resp.valid in the same cycle as memresp.valid, next accept at the earliest 1 cycle after the response.
REQ-022 SHALL drive resp.rdata/error/errty for the non-owner and in non-WAIT_RESP states as 0 / 0 / FE_ACCESS_FAULT.

Reset
REQ-023 SHALL, while reset_n=0, set state=IDLE and last_grant=D (so port I wins the first tie), and clear the latched addr/wdata/wen/owner to 0.
REQ-024 SHALL, while reset_n=0, force all ready, memreq.valid and resp.valid outputs to 0 regardless of inputs.
REQ-025 SHALL, on reset mid-transaction, abandon the transaction; its late memresp is dropped per REQ-019.

Structure
REQ-026 SHALL use CacheReq, CacheResp and FaultTy from the shared package; a new shared typedef ArbPort (I, D) SHALL be added there for reuse by later multi-port blocks.
REQ-027 SHALL keep the state enum local to the module.
REQ-028 SHALL place the grant logic in sub-module rr_grant2 (inputs: two valids, last_grant, FIXED_PRIORITY; output: one-hot grant).

Verification
REQ-029 SHALL cover: I only, read addr 0x8000_1000 -> memreq.addr=0x8000_1000 at N+1; memresp rdata 0x0000_00CF -> iresp.valid=1, iresp.rdata=0x0000_00CF, dresp.valid=0.
REQ-030 SHALL cover: I and D valid together in IDLE after reset -> I granted first, D granted next; repeat with both valid -> grants alternate I, D, I, D; with FIXED_PRIORITY=1 -> I granted every time.
REQ-031 SHALL cover: D write addr 0x8040_0008, wdata 0x0000_00C7, requester drops valid after ready -> memreq.wen=1, wdata held; D then re-requests -> dreq.ready stays 0 until memresp.valid, then accepted.
REQ-032 SHALL cover: memresp.error=1, errty=FE_PAGE_FAULT for owner D -> dresp.error=1, errty=FE_PAGE_FAULT; iresp.valid=0.
REQ-033 SHALL cover: memreq.ready held 0 for 5 cycles -> memreq.valid and addr stable all 5 cycles; no ready to either port.
REQ-034 SHALL cover: reset_n pulsed low during WAIT_RESP, then a stray memresp.valid -> no resp.valid on either port; state=IDLE; the next request is served normally.
